// File: rtl/ibex_fp_pkg.sv
// Shared FP issue definitions: FPU opcodes, issue FSM states and the
// register-file geometry used by the issue stage and its scoreboard.
package ibex_fp_pkg;

  localparam int unsigned NUM_FP_REGS = 32;
  localparam int unsigned FP_ADDR_W   = 5;
  localparam int unsigned FLEN        = 32;

  typedef logic [FP_ADDR_W-1:0] fp_addr_t;

  typedef enum logic [3:0] {
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_DIV,
    FPU_SQRT,
    FPU_MIN_MAX,
    FPU_FMADD,
    FPU_FMSUB,
    FPU_FNMADD,
    FPU_FNMSUB,
    FPU_SGNJ,
    FPU_CMP,
    FPU_CLASS,
    FPU_F2I,
    FPU_I2F,
    FPU_MV
  } fpu_op_e;

  typedef enum logic [1:0] {
    ISSUE_IDLE,
    ISSUE_HOLD,
    ISSUE_OUT
  } issue_state_e;

  // Instruction fields captured on the instruction-side handshake.
  typedef struct packed {
    fpu_op_e                     op;
    logic [2:0]                  rm;
    logic [2:0][FP_ADDR_W-1:0]   rs_addr;
    logic [2:0]                  rs_use;
    fp_addr_t                    rd;
    logic                        rd_is_int;
  } issue_instr_t;

  function automatic logic [NUM_FP_REGS-1:0] addr_onehot(input fp_addr_t addr);
    logic [NUM_FP_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/fpu_scoreboard.sv
// One pending bit per FP register: set when a result is in flight to the
// FPU, cleared when that register is written back. Set beats clear.
module fpu_scoreboard
  import ibex_fp_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   set_valid_i,
  input  fp_addr_t               set_addr_i,
  input  logic                   clr_valid_i,
  input  fp_addr_t               clr_addr_i,
  output logic [NUM_FP_REGS-1:0] pending_o
);

  logic [NUM_FP_REGS-1:0] set_mask;
  logic [NUM_FP_REGS-1:0] clr_mask;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid_i) set_mask = addr_onehot(set_addr_i);
    if (clr_valid_i) clr_mask = addr_onehot(clr_addr_i);
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge; every flop here is a plain register and is reset, there is no RAM array to leave unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/fpu_issue_stage.sv
// FP issue stage: holds one instruction, stalls on register hazards,
// reads/bypasses operands and presents them to the FPU with valid/ready.
module fpu_issue_stage
  import ibex_fp_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  fpu_op_e                    fp_op_i,
  input  logic [2:0]                 rm_i,
  input  logic [2:0][FP_ADDR_W-1:0]  rs_addr_i,
  input  logic [2:0]                 rs_use_i,
  input  logic [FP_ADDR_W-1:0]       rd_addr_i,
  input  logic                       rd_is_int_i,

  output logic [2:0][FP_ADDR_W-1:0]  rf_raddr_o,
  input  logic [2:0][FLEN-1:0]       rf_rdata_i,

  input  logic                       wb_valid_i,
  input  logic [FP_ADDR_W-1:0]       wb_addr_i,
  input  logic [FLEN-1:0]            wb_data_i,

  output logic                       fpu_valid_o,
  input  logic                       fpu_ready_i,
  output fpu_op_e                    fp_op_o,
  output logic [2:0]                 rm_o,
  output logic [FLEN-1:0]            rs1_o,
  output logic [FLEN-1:0]            rs2_o,
  output logic [FLEN-1:0]            rs3_o,
  output logic [FP_ADDR_W-1:0]       rd_addr_o,
  output logic                       rd_is_int_o,

  input  logic                       flush_i,
  output logic                       busy_o
);

  issue_state_e           state_q, state_d;
  issue_instr_t           held_q;
  logic [NUM_FP_REGS-1:0] pending;
  logic [NUM_FP_REGS-1:0] pending_eff;
  logic [2:0][FLEN-1:0]   operand_d;
  logic                   hazard;
  logic                   accept;
  logic                   capture;
  logic                   fpu_hs;

  assign rf_raddr_o  = held_q.rs_addr;
  assign fpu_valid_o = (state_q == ISSUE_OUT);
  assign fpu_hs      = fpu_valid_o & fpu_ready_i & ~flush_i;
  assign busy_o      = (state_q != ISSUE_IDLE) | (|pending);

  // A register being written back this cycle no longer blocks its readers.
  always_comb begin
    pending_eff = pending;
    if (wb_valid_i) pending_eff = pending & ~addr_onehot(wb_addr_i);
    hazard = ~held_q.rd_is_int & pending_eff[held_q.rd];
    for (int i = 0; i < 3; i++) begin
      hazard = hazard | (held_q.rs_use[i] & pending_eff[held_q.rs_addr[i]]);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      operand_d[i] = '0;
      if (held_q.rs_use[i]) begin
        if (wb_valid_i && (wb_addr_i == held_q.rs_addr[i])) operand_d[i] = wb_data_i;
        else                                                 operand_d[i] = rf_rdata_i[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_ready_o = (state_q == ISSUE_IDLE) | ((state_q == ISSUE_OUT) & fpu_ready_i);
    unique case (state_q)
      ISSUE_IDLE: if (instr_valid_i) state_d = ISSUE_HOLD;
      ISSUE_HOLD: if (!hazard) state_d = ISSUE_OUT;
      ISSUE_OUT:  if (fpu_ready_i) state_d = instr_valid_i ? ISSUE_HOLD : ISSUE_IDLE;
      default:    state_d = ISSUE_IDLE;
    endcase
    if (flush_i) state_d = ISSUE_IDLE;
  end

  assign accept  = instr_valid_i & instr_ready_o & ~flush_i;
  assign capture = (state_q == ISSUE_HOLD) & ~hazard & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ISSUE_IDLE;
      held_q      <= '0;
      fp_op_o     <= FPU_ADD;
      rm_o        <= '0;
      rs1_o       <= '0;
      rs2_o       <= '0;
      rs3_o       <= '0;
      rd_addr_o   <= '0;
      rd_is_int_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        held_q <= '{op:        fp_op_i,
                    rm:        rm_i,
                    rs_addr:   rs_addr_i,
                    rs_use:    rs_use_i,
                    rd:        rd_addr_i,
                    rd_is_int: rd_is_int_i};
      end
      if (capture) begin
        fp_op_o     <= held_q.op;
        rm_o        <= held_q.rm;
        rs1_o       <= operand_d[0];
        rs2_o       <= operand_d[1];
        rs3_o       <= operand_d[2];
        rd_addr_o   <= held_q.rd;
        rd_is_int_o <= held_q.rd_is_int;
      end
    end
  end

  fpu_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_valid_i (fpu_hs & ~rd_is_int_o),
    .set_addr_i  (rd_addr_o),
    .clr_valid_i (wb_valid_i),
    .clr_addr_i  (wb_addr_i),
    .pending_o   (pending)
  );

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Directed bench for fpu_issue_stage: expected FPU transactions are queued
// at stimulus time and compared when the FPU handshake is observed.
module tb_fpu_issue_stage;
  import ibex_fp_pkg::*;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 instr_valid_i;
  logic                 instr_ready_o;
  fpu_op_e              fp_op_i;
  logic [2:0]           rm_i;
  logic [2:0][4:0]      rs_addr_i;
  logic [2:0]           rs_use_i;
  logic [4:0]           rd_addr_i;
  logic                 rd_is_int_i;
  logic [2:0][4:0]      rf_raddr_o;
  logic [2:0][31:0]     rf_rdata_i;
  logic                 wb_valid_i;
  logic [4:0]           wb_addr_i;
  logic [31:0]          wb_data_i;
  logic                 fpu_valid_o;
  logic                 fpu_ready_i;
  fpu_op_e              fp_op_o;
  logic [2:0]           rm_o;
  logic [31:0]          rs1_o, rs2_o, rs3_o;
  logic [4:0]           rd_addr_o;
  logic                 rd_is_int_o;
  logic                 flush_i;
  logic                 busy_o;

  fpu_issue_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .fp_op_i(fp_op_i), .rm_i(rm_i), .rs_addr_i(rs_addr_i), .rs_use_i(rs_use_i),
    .rd_addr_i(rd_addr_i), .rd_is_int_i(rd_is_int_i),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
    .fp_op_o(fp_op_o), .rm_o(rm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rs3_o(rs3_o),
    .rd_addr_o(rd_addr_o), .rd_is_int_o(rd_is_int_o),
    .flush_i(flush_i), .busy_o(busy_o)
  );

  typedef struct {
    fpu_op_e     op;
    logic [2:0]  rm;
    logic [31:0] rs1, rs2, rs3;
    logic [4:0]  rd;
    logic        is_int;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fp_rf [32];
  logic [31:0] pend_exp;
  logic        hs_instr;
  int          checks = 0;
  int          errors = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int i = 0; i < 3; i++) rf_rdata_i[i] = fp_rf[rf_raddr_o[i]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void expect_issue(input fpu_op_e op, input logic [2:0] rm,
                                       input logic [31:0] r1, r2, r3,
                                       input logic [4:0] rd, input logic is_int);
    exp_t e;
    e.op = op; e.rm = rm; e.rs1 = r1; e.rs2 = r2; e.rs3 = r3; e.rd = rd; e.is_int = is_int;
    exp_q.push_back(e);
  endfunction

  // One clock: sample at the falling edge, score FPU handshakes, update the
  // pending-bit model (clear then set, so set wins), then step past the edge.
  task automatic tick();
    exp_t e;
    logic set_v;
    logic [4:0] set_a;
    @(negedge clk_i);
    set_v    = 1'b0;
    set_a    = '0;
    hs_instr = instr_valid_i && instr_ready_o && !flush_i && rst_ni;
    if (rst_ni && !flush_i && fpu_valid_o && fpu_ready_i) begin
      check("expected_issue", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("fp_op", 32'(fp_op_o), 32'(e.op));
        check("rm", 32'(rm_o), 32'(e.rm));
        check("rs1", rs1_o, e.rs1);
        check("rs2", rs2_o, e.rs2);
        check("rs3", rs3_o, e.rs3);
        check("rd", 32'(rd_addr_o), 32'(e.rd));
        check("rd_is_int", 32'(rd_is_int_o), 32'(e.is_int));
        set_v = !e.is_int;
        set_a = e.rd;
      end
    end
    if (rst_ni && wb_valid_i) pend_exp[wb_addr_i] = 1'b0;
    if (set_v) pend_exp[set_a] = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input fpu_op_e op, input logic [2:0] rm, input logic [4:0] a1, a2, a3,
                       input logic [2:0] use_mask, input logic [4:0] rd, input logic is_int);
    fp_op_i = op; rm_i = rm; rs_addr_i = {a3, a2, a1}; rs_use_i = use_mask;
    rd_addr_i = rd; rd_is_int_i = is_int; instr_valid_i = 1'b1;
    hs_instr = 1'b0;
    for (int i = 0; i < 20 && !hs_instr; i++) tick();
    instr_valid_i = 1'b0;
    check("instr_handshake", 32'(hs_instr), 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !fpu_valid_o; i++) tick();
    check("fpu_valid_wait", 32'(fpu_valid_o), 32'd1);
  endtask

  task automatic writeback(input logic [4:0] addr, input logic [31:0] data);
    wb_valid_i = 1'b1; wb_addr_i = addr; wb_data_i = data;
    tick();
    wb_valid_i = 1'b0;
    fp_rf[addr] = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) fp_rf[i] = 32'h3F80_0000 + 32'(i);
    fp_rf[1] = 32'h4023_D70A;
    fp_rf[2] = 32'h4120_0000;
    fp_rf[4] = 32'hDEAD_BEEF;
    pend_exp = '0;
    rst_ni = 1'b0; instr_valid_i = 1'b0; fp_op_i = FPU_ADD; rm_i = '0;
    rs_addr_i = '0; rs_use_i = '0; rd_addr_i = '0; rd_is_int_i = 1'b0;
    wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    fpu_ready_i = 1'b1; flush_i = 1'b0; hs_instr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_fpu_valid", 32'(fpu_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_rs1", rs1_o, 32'd0);
    rst_ni = 1'b1;
    tick();
    check("rst_instr_ready", 32'(instr_ready_o), 32'd1);

    // Basic add, 2-cycle latency, pending[3] set
    expect_issue(FPU_ADD, 3'd0, 32'h4023_D70A, 32'h4120_0000, 32'd0, 5'd3, 1'b0);
    issue(FPU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd3, 1'b0);
    check("lat_hold_valid", 32'(fpu_valid_o), 32'd0);
    check("hold_ready", 32'(instr_ready_o), 32'd0);
    check("hold_raddr", 32'(rf_raddr_o), 32'({5'd0, 5'd2, 5'd1}));
    tick();
    check("lat_out_valid", 32'(fpu_valid_o), 32'd1);
    tick();
    check("pending3", 32'(dut.pending[3]), 32'd1);
    check("pending_vec_a", dut.pending, pend_exp);
    check("busy_pending", 32'(busy_o), 32'd1);

    // Hazard stall and writeback bypass
    writeback(5'd3, 32'h4049_0FDB);
    check("pending_vec_b", dut.pending, pend_exp);
    expect_issue(FPU_SUB, 3'd1, fp_rf[1], fp_rf[2], 32'd0, 5'd4, 1'b0);
    issue(FPU_SUB, 3'd1, 5'd1, 5'd2, 5'd0, 3'b011, 5'd4, 1'b0);
    wait_valid();
    tick();
    expect_issue(FPU_SUB, 3'd2, 32'h4049_0FDB, 32'hC0F5_C28F, 32'd0, 5'd5, 1'b0);
    issue(FPU_SUB, 3'd2, 5'd3, 5'd4, 5'd0, 3'b011, 5'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hazard_stall", 32'(fpu_valid_o), 32'd0);
    end
    writeback(5'd4, 32'hC0F5_C28F);
    check("bypass_valid", 32'(fpu_valid_o), 32'd1);
    check("bypass_rs2", rs2_o, 32'hC0F5_C28F);
    tick();

    // Backpressure for 5 cycles, then back-to-back issue
    fpu_ready_i = 1'b0;
    expect_issue(FPU_MUL, 3'd3, fp_rf[1], fp_rf[2], 32'd0, 5'd8, 1'b1);
    issue(FPU_MUL, 3'd3, 5'd1, 5'd2, 5'd0, 3'b011, 5'd8, 1'b1);
    wait_valid();
    expect_issue(FPU_DIV, 3'd4, fp_rf[2], fp_rf[1], 32'd0, 5'd9, 1'b1);
    fp_op_i = FPU_DIV; rm_i = 3'd4; rs_addr_i = {5'd0, 5'd1, 5'd2}; rs_use_i = 3'b011;
    rd_addr_i = 5'd9; rd_is_int_i = 1'b1; instr_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(fpu_valid_o), 32'd1);
      check("stall_ready", 32'(instr_ready_o), 32'd0);
      check("stall_rs1", rs1_o, fp_rf[1]);
      check("stall_rd", 32'(rd_addr_o), 32'd8);
    end
    fpu_ready_i = 1'b1;
    tick();
    check("b2b_accept", 32'(hs_instr), 32'd1);
    instr_valid_i = 1'b0;
    check("b2b_hold", 32'(fpu_valid_o), 32'd0);
    tick();
    check("b2b_out", 32'(fpu_valid_o), 32'd1);
    check("b2b_rd", 32'(rd_addr_o), 32'd9);
    tick();

    // Simultaneous set and clear of pending[6]
    fpu_ready_i = 1'b0;
    expect_issue(FPU_ADD, 3'd0, fp_rf[1], fp_rf[2], 32'd0, 5'd6, 1'b0);
    issue(FPU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd6, 1'b0);
    wait_valid();
    fpu_ready_i = 1'b1;
    writeback(5'd6, 32'h1234_5678);
    check("set_wins", 32'(dut.pending[6]), 32'd1);
    check("pending_vec_c", dut.pending, pend_exp);

    // Flush while held on a hazard
    issue(FPU_FMADD, 3'd0, 5'd6, 5'd1, 5'd2, 3'b111, 5'd10, 1'b0);
    tick();
    check("flush_hold_pre", 32'(fpu_valid_o), 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_hold_ready", 32'(instr_ready_o), 32'd1);
    check("flush_hold_valid", 32'(fpu_valid_o), 32'd0);
    check("flush_hold_pend", dut.pending, pend_exp);

    // Flush while presenting to the FPU, same cycle as ready
    fpu_ready_i = 1'b0;
    issue(FPU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd11, 1'b0);
    wait_valid();
    flush_i = 1'b1; fpu_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_out_valid", 32'(fpu_valid_o), 32'd0);
    check("flush_out_ready", 32'(instr_ready_o), 32'd1);
    check("flush_out_pend11", 32'(dut.pending[11]), 32'd0);
    check("flush_out_pend", dut.pending, pend_exp);
    tick();
    check("flush_out_idle", 32'(fpu_valid_o), 32'd0);

    // Asynchronous reset while in OUT with pending[7] set
    expect_issue(FPU_ADD, 3'd0, fp_rf[1], fp_rf[2], 32'd0, 5'd7, 1'b0);
    issue(FPU_ADD, 3'd0, 5'd1, 5'd2, 5'd0, 3'b011, 5'd7, 1'b0);
    wait_valid();
    tick();
    check("pending7", 32'(dut.pending[7]), 32'd1);
    fpu_ready_i = 1'b0;
    issue(FPU_MUL, 3'd5, 5'd1, 5'd2, 5'd0, 3'b011, 5'd12, 1'b0);
    wait_valid();
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 32'(fpu_valid_o), 32'd0);
    check("arst_rs1", rs1_o, 32'd0);
    check("arst_rs2", rs2_o, 32'd0);
    check("arst_rd", 32'(rd_addr_o), 32'd0);
    check("arst_op", 32'(fp_op_o), 32'd0);
    check("arst_pending", dut.pending, 32'd0);
    pend_exp = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    fpu_ready_i = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_ready", 32'(instr_ready_o), 32'd1);
    check("post_rst_valid", 32'(fpu_valid_o), 32'd0);

    // Normal operation resumes after reset
    expect_issue(FPU_SUB, 3'd6, fp_rf[2], fp_rf[1], 32'd0, 5'd13, 1'b0);
    issue(FPU_SUB, 3'd6, 5'd2, 5'd1, 5'd0, 3'b011, 5'd13, 1'b0);
    wait_valid();
    tick();
    check("final_pend", dut.pending, pend_exp);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_stage.md
FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have the port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have these instruction-side ports: instr_valid_i in 1; instr_ready_o out 1; fp_op_i in fpu_op_e; rm_i in 3; rs_addr_i in 3x5 (rs1, rs2, rs3); rs_use_i in 3 (per-source used flag); rd_addr_i in 5; rd_is_int_i in 1 (result goes to int regfile).
REQ-004 The block SHALL have these FP regfile read ports: rf_raddr_o out 3x5; rf_rdata_i in 3x32 (combinational read).
REQ-005 The block SHALL have these writeback snoop ports: wb_valid_i in 1; wb_addr_i in 5; wb_data_i in 32 (FP regfile write this cycle).
REQ-006 The block SHALL have these FPU-side ports: fpu_valid_o out 1; fpu_ready_i in 1; fp_op_o out fpu_op_e; rm_o out 3; rs1_o, rs2_o, rs3_o out 32 each; rd_addr_o out 5; rd_is_int_o out 1.
REQ-007 The block SHALL have these control ports: flush_i in 1 (drop held instruction); busy_o out 1 (state != IDLE or any scoreboard bit set).

Function
REQ-008 The FSM SHALL have exactly three states: IDLE (nothing held), HOLD (instruction held, hazard check), OUT (operands registered, fpu_valid_o=1).
REQ-009 instr_ready_o SHALL be 1 in IDLE, and 1 in OUT only when fpu_ready_i=1; it SHALL be 0 in HOLD.
REQ-010 On an instr_valid_i and instr_ready_o handshake, op, rm, rs_addr, rs_use, rd and rd_is_int SHALL be registered and the state SHALL become HOLD.
REQ-011 In HOLD, rf_raddr_o SHALL equal the held rs addresses; the hazard condition SHALL be: any used source with its pending bit set, or rd_is_int=0 with the rd pending bit set.
REQ-012 A pending bit whose address equals wb_addr_i while wb_valid_i=1 SHALL be treated as clear for the hazard check in that same cycle.
REQ-013 In HOLD with no hazard, operands SHALL be captured (wb_data_i overriding rf_rdata_i on an address match with wb_valid_i=1; unused sources SHALL be captured as 0) and the state SHALL become OUT; with a hazard the state SHALL remain HOLD.
REQ-014 In OUT, outputs SHALL remain stable until fpu_ready_i=1; on handshake the state SHALL be HOLD if a new instruction is accepted in the same cycle, else IDLE.
REQ-015 Minimum latency SHALL be 2 cycles from instruction handshake to fpu_valid_o; sustained throughput SHALL be one instruction per 2 cycles without hazards.
REQ-016 The scoreboard SHALL be 32 pending bits; f0 SHALL be a normal register (not hardwired).
REQ-017 A pending bit SHALL be set on the FPU handshake when rd_is_int_o=0, and cleared on wb_valid_i for wb_addr_i.
REQ-018 On a simultaneous set and clear of the same bit, set SHALL win.
REQ-019 flush_i SHALL force IDLE next cycle and deassert fpu_valid_o; it SHALL NOT alter the scoreboard; flush_i SHALL take priority over any handshake in that cycle, which SHALL NOT set a bit.

Reset
REQ-020 While rst_ni=0: state=IDLE, scoreboard=0, fpu_valid_o=0, all registered data outputs=0, instr_ready_o=1 after release.
REQ-021 Reset mid-operation SHALL discard the held instruction and all pending bits without producing an FPU handshake.

Structure
REQ-022 fpu_op_e and the FSM state enum SHALL live in the shared ibex_fp_pkg; the register count (32) and address width (5) SHALL be package constants.
REQ-023 The scoreboard SHALL be a sub-module fpu_scoreboard (set/clear ports, pending vector out); the FSM and operand capture SHALL stay in fpu_issue_stage.

Verification
REQ-024 f1=0x4023D70A, f2=0x41200000, FPU_ADD rs1=1 rs2=2 rd=3, fpu_ready_i=1 -> fpu_valid_o two cycles after handshake, rs1_o=0x4023D70A, rs2_o=0x41200000, pending[3] set.
REQ-025 FPU_SUB rd=4 issued, then FPU_SUB rs1=3 rs2=4 rd=5 -> held in HOLD until wb_valid_i with wb_addr_i=4, wb_data_i=0xC0F5C28F; issued in that cycle's successor with rs2_o=0xC0F5C28F (bypass).
REQ-026 fpu_ready_i=0 for 5 cycles in OUT -> outputs stable, instr_ready_o=0, a second instruction waits, then issues back-to-back on release.
REQ-027 Issue of rd=6 in the same cycle as wb_valid_i for wb_addr_i=6 -> pending[6] ends at 1.
REQ-028 flush_i in HOLD and separately in OUT -> IDLE next cycle, no FPU handshake, scoreboard unchanged.
REQ-029 rst_ni pulsed low while in OUT with pending[7]=1 -> all outputs 0 asynchronously, busy_o=0 after reset.
